// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - func3 size codes for the load/store request
//   - responder state encoding
//   - helpers mapping a func3 code to an access size and a byte-lane mask
// -----------------------------------------------------------------------------
package dmem_pkg;

  // func3 size codes (RISC-V load/store encoding)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Access size in bytes; 0 marks an illegal code.
  function automatic logic [2:0] f3_size(input logic [2:0] func3);
    case (func3)
      F3_B, F3_BU: f3_size = 3'd1;
      F3_H, F3_HU: f3_size = 3'd2;
      F3_W:        f3_size = 3'd4;
      default:     f3_size = 3'd0;
    endcase
  endfunction

  // Right-aligned byte-lane mask covering `size` bytes.
  function automatic logic [3:0] size_lanes(input logic [2:0] size);
    case (size)
      3'd1:    size_lanes = 4'b0001;
      3'd2:    size_lanes = 4'b0011;
      3'd4:    size_lanes = 4'b1111;
      default: size_lanes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// -----------------------------------------------------------------------------
// dmem_bram
// Single-port DEPTH x 32 synchronous RAM with per-byte write enables and a
// registered read port (read-before-write, 1-cycle latency). The read register
// only updates when i_en is high, so the output holds between accesses.
//
// Ports:
//   clk      in   clock
//   i_en     in   access enable (read always, write lanes selected by i_be)
//   i_be     in   byte write enables, lane 0 = bits [7:0]
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module dmem_bram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  // NOTE: non-blocking assignments keep the read returning the pre-write word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder at the far end of the load/store interface. Accepts one
// request at a time, performs it on an internal byte-enabled RAM and returns
// zero/sign-extended load data through a valid/ready response handshake.
// Accesses that straddle a word boundary are split into two word beats.
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses are not
//                          performed; they return rsp_err=1 instead of being
//                          split.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  request accepted (high only in IDLE)
//   req_we     in   1 = store, 0 = load
//   req_func3  in   size code B/H/W/BU/HU
//   req_addr   in   byte address (upper bits alias)
//   req_wdata  in   right-aligned store data
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rsp_rdata  out  extended load data, 0 for stores and errors
//   rsp_err    out  illegal func3, or trapped misaligned access
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  import dmem_pkg::*;

  localparam int IW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the incoming request, latched on accept)
  // ---------------------------------------------------------------------------
  logic [2:0]    w_size;
  logic [1:0]    w_off;
  logic [IW-1:0] w_w0;
  logic          w_illegal;
  logic          w_cross;
  logic          w_err;
  logic          w_split;
  logic          w_unused_addr;

  assign w_size    = f3_size(req_func3);
  assign w_off     = req_addr[1:0];
  assign w_w0      = req_addr[IW+1:2];
  // Unsigned loads have no store counterpart.
  assign w_illegal = (w_size == 3'd0) || (req_we && req_func3[2]);
  assign w_cross   = ({1'b0, w_off} + w_size) > 3'd4;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == 3'd2) && w_off[0]) ||
                        ((w_size == 3'd4) && (w_off != 2'd0));
  assign w_err = w_illegal || w_misaligned;
`else
  assign w_err = w_illegal;
`endif

  // Errored requests never take the second beat.
  assign w_split = w_cross && !w_err;

  // Address bits above the RAM index alias onto the same words.
  assign w_unused_addr = ^req_addr[AW-1:IW+2];

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          r_we;
  logic          r_err;
  logic          r_cross;
  logic [2:0]    r_func3;
  logic [2:0]    r_size;
  logic [1:0]    r_off;
  logic [IW-1:0] r_w0;
  logic [31:0]   r_wdata;
  logic [31:0]   r_word0;

  // RAM interface
  logic          w_ram_en;
  logic [3:0]    w_ram_be;
  logic [IW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;

  // ---------------------------------------------------------------------------
  // Store lane placement: the request is shifted into a two-word window; the
  // low word belongs to w0 and the high word to w0+1.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_lanes;
  logic [63:0] w_wpair;

  assign w_lanes = {4'b0000, size_lanes(r_size)} << r_off;
  assign w_wpair = {32'd0, r_wdata} << {r_off, 3'b000};

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_be    = 4'b0000;
    w_ram_addr  = r_w0;
    w_ram_wdata = w_wpair[31:0];
    // Gating with rst drops a beat that coincides with reset.
    if (rst && !r_err) begin
      case (r_state)
        WORD0: begin
          w_ram_en = 1'b1;
          if (r_we) w_ram_be = w_lanes[3:0];
        end
        WORD1: begin
          w_ram_en    = 1'b1;
          w_ram_addr  = r_w0 + IW'(1);  // wraps from the last word to word 0
          w_ram_wdata = w_wpair[63:32];
          if (r_we) w_ram_be = w_lanes[7:4];
        end
        default: begin
        end
      endcase
    end
  end

  dmem_bram #(
    .DEPTH(DEPTH)
  ) u_bram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_be   (w_ram_be),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> WORD0 -> [WORD1] -> RESP -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_cross     <= 1'b0;
      r_func3     <= 3'b000;
      r_size      <= 3'd0;
      r_off       <= 2'd0;
      r_w0        <= '0;
      r_wdata     <= 32'd0;
      r_word0     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_func3     <= req_func3;
            r_size      <= w_size;
            r_off       <= w_off;
            r_w0        <= w_w0;
            r_wdata     <= req_wdata;
            r_err       <= w_err;
            r_cross     <= w_split;
            r_req_ready <= 1'b0;
            r_state     <= WORD0;
          end
        end
        WORD0: begin
          if (r_cross) begin
            r_state <= WORD1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_state     <= RESP;
          end
        end
        WORD1: begin
          // The WORD0 read lands now; hold it while the second word is read.
          r_word0     <= w_ram_rdata;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load data: little-endian byte pair window, extracted from offset o.
  // Both sources are registers that hold still in RESP (the RAM is idle), so
  // the response stays stable under backpressure.
  // ---------------------------------------------------------------------------
  logic [63:0] w_pair;
  logic [31:0] w_aligned;
  logic [31:0] w_ext;

  assign w_pair    = {w_ram_rdata, (r_cross ? r_word0 : w_ram_rdata)};
  assign w_aligned = w_pair[{r_off, 3'b000} +: 32];

  always_comb begin
    case (r_func3)
      F3_B:    w_ext = {{24{w_aligned[7]}}, w_aligned[7:0]};
      F3_BU:   w_ext = {24'd0, w_aligned[7:0]};
      F3_H:    w_ext = {{16{w_aligned[15]}}, w_aligned[15:0]};
      F3_HU:   w_ext = {16'd0, w_aligned[15:0]};
      default: w_ext = w_aligned;
    endcase
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = (r_rsp_valid && !r_we && !r_rsp_err) ? w_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int AW      = 32;
  localparam int MAXWAIT = 12;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we    = 1'b0;
  logic [2:0]  req_func3 = 3'b010;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_func3(req_func3),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } txn_t;

  exp_t       sb[$];
  logic [7:0] mdl [4*DEPTH];

  // Drives one request at a negedge with the DUT idle and rsp_ready high.
  // lat = index of the edge (relative to the accept edge) at which rsp_valid
  // is first presented.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < MAXWAIT) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
  endtask

  // Byte-level reference model of one access; updates mdl for legal stores.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output exp_t e);
    int s;
    logic [1:0] o;
    logic [31:0] v, ba;
    bit bad;
    case (f3)
      3'b000, 3'b100: s = 1;
      3'b001, 3'b101: s = 2;
      3'b010:         s = 4;
      default:        s = 0;
    endcase
    o = addr[1:0];
    bad = (s == 0) || (we && f3[2]) || (TRAP && ((s == 2 && o[0]) || (s == 4 && o != 2'd0)));
    if (bad) begin
      e = '{32'h0, 1'b1, 2};
    end else begin
      v = 32'h0;
      for (int i = 0; i < s; i++) begin
        ba = (addr + 32'(i)) & 32'(4*DEPTH-1);
        if (we) mdl[ba] = wd[8*i +: 8];
        else    v[8*i +: 8] = mdl[ba];
      end
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      e = '{(we ? 32'h0 : v), 1'b0, ((int'(o) + s > 4) ? 3 : 2)};
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL reset req_ready got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL reset rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0)    begin failures++; $display("FAIL reset rsp_err got=%b want=0", rsp_err); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    txn_t t[$];
    exp_t e;
    logic [31:0] rd; logic er; int lat;
    t.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0,       32'hDEADBEEF, 1'b0, 2});
    t.push_back('{1'b0, 3'b000, 32'h13, 32'h0,       32'hFFFFFFDE, 1'b0, 2});
    t.push_back('{1'b0, 3'b100, 32'h13, 32'h0,       32'h000000DE, 1'b0, 2});
    t.push_back('{1'b0, 3'b001, 32'h12, 32'h0,       32'hFFFFDEAD, 1'b0, 2});
    t.push_back('{1'b0, 3'b101, 32'h12, 32'h0,       32'h0000DEAD, 1'b0, 2});
    t.push_back('{1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0,       1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0,       32'hDEAD55EF, 1'b0, 2});
    t.push_back('{1'b1, 3'b001, 32'h10, 32'h00001234, 32'h0,       1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0,       32'hDEAD1234, 1'b0, 2});
    t.push_back('{1'b1, 3'b010, 32'h20, 32'h0BADF00D, 32'h0,       1'b0, 2});
    foreach (t[i]) begin
      sb.push_back('{t[i].rdata, t[i].err, t[i].lat});
      xfer(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL basic[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL basic[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL basic[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_misalign();
    txn_t t[$];
    exp_t e;
    logic [31:0] rd; logic er; int lat;
    t.push_back('{1'b1, 3'b010, 32'h0C, 32'h11223344, 32'h0, 1'b0, 2});
    t.push_back('{1'b1, 3'b010, 32'h10, 32'hDEAD55EF, 32'h0, 1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'h0E, 32'h0, (TRAP ? 32'h0 : 32'h55EF1122), TRAP, (TRAP ? 2 : 3)});
    t.push_back('{1'b1, 3'b010, 32'h0D, 32'hCAFEBABE, 32'h0, TRAP, (TRAP ? 2 : 3)});
    t.push_back('{1'b0, 3'b010, 32'h0C, 32'h0, (TRAP ? 32'h11223344 : 32'hFEBABE44), 1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0, (TRAP ? 32'hDEAD55EF : 32'hDEAD55CA), 1'b0, 2});
    t.push_back('{1'b0, 3'b001, 32'h0F, 32'h0, (TRAP ? 32'h0 : 32'hFFFFCAFE), TRAP, (TRAP ? 2 : 3)});
    t.push_back('{1'b0, 3'b101, 32'h0E, 32'h0, (TRAP ? 32'h00001122 : 32'h0000FEBA), 1'b0, 2});
    t.push_back('{1'b0, 3'b100, 32'h0F, 32'h0, (TRAP ? 32'h00000011 : 32'h000000FE), 1'b0, 2});
    foreach (t[i]) begin
      sb.push_back('{t[i].rdata, t[i].err, t[i].lat});
      xfer(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL misalign[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL misalign[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL misalign[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  // Backpressure, busy requests ignored, then illegal codes.
  task automatic test_backpressure();
    txn_t t[$];
    exp_t e;
    logic [31:0] rd; logic er; int lat;
    rsp_ready = 1'b0;
    sb.push_back('{(TRAP ? 32'hDEAD55EF : 32'hDEAD55CA), 1'b0, 2});
    req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // A store presented while busy must be dropped.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < MAXWAIT) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL bp latency got=%0d want=%0d", lat, e.lat); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (rsp_valid !== 1'b1)    begin failures++; $display("FAIL bp[%0d] rsp_valid got=%b want=1", k, rsp_valid); end
      checks++; if (rsp_rdata !== e.rdata) begin failures++; $display("FAIL bp[%0d] rdata got=%h want=%h", k, rsp_rdata, e.rdata); end
      checks++; if (req_ready !== 1'b0)    begin failures++; $display("FAIL bp[%0d] req_ready got=%b want=0", k, req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL bp_done rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL bp_done rdata got=%h want=0", rsp_rdata); end
    checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL bp_done req_ready got=%b want=1", req_ready); end
    t.push_back('{1'b0, 3'b010, 32'h20, 32'h0,       32'h0BADF00D, 1'b0, 2});
    t.push_back('{1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0,       1'b1, 2});
    t.push_back('{1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,       1'b1, 2});
    t.push_back('{1'b1, 3'b101, 32'h20, 32'hFFFFFFFF, 32'h0,       1'b1, 2});
    t.push_back('{1'b0, 3'b110, 32'h20, 32'h0,       32'h0,        1'b1, 2});
    t.push_back('{1'b0, 3'b111, 32'h20, 32'h0,       32'h0,        1'b1, 2});
    t.push_back('{1'b0, 3'b010, 32'h20, 32'h0,       32'h0BADF00D, 1'b0, 2});
    foreach (t[i]) begin
      sb.push_back('{t[i].rdata, t[i].err, t[i].lat});
      xfer(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL illegal[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL illegal[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL illegal[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  // Word-index wrap, address aliasing and reset during the second store beat.
  task automatic test_reset_mid();
    txn_t t[$];
    exp_t e;
    logic [31:0] rd; logic er; int lat;
    t.push_back('{1'b1, 3'b010, 32'hFFC,  32'hAAAAAAAA, 32'h0,        1'b0, 2});
    t.push_back('{1'b1, 3'b010, 32'h000,  32'h55555555, 32'h0,        1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'hFFE,  32'h0, (TRAP ? 32'h0 : 32'h5555AAAA), TRAP, (TRAP ? 2 : 3)});
    t.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h55555555, 1'b0, 2});
    foreach (t[i]) begin
      sb.push_back('{t[i].rdata, t[i].err, t[i].lat});
      xfer(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL wrap[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL wrap[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL wrap[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
    // Crossing SW at the last word; reset lands on the second-beat edge.
    req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'hFFE; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid req_ready got=%b want=1", req_ready); end
    rst = 1'b1;
    t.delete();
    t.push_back('{1'b0, 3'b010, 32'h000, 32'h0, 32'h55555555, 1'b0, 2});
    t.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0, (TRAP ? 32'hAAAAAAAA : 32'h5678AAAA), 1'b0, 2});
    foreach (t[i]) begin
      sb.push_back('{t[i].rdata, t[i].err, t[i].lat});
      xfer(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rstmid[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL rstmid[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL rstmid[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  // Random mix of accesses in a pre-initialised region against the byte model.
  task automatic test_random();
    exp_t e, m;
    logic [31:0] rd, addr, wd; logic er; int lat;
    logic we; logic [2:0] f3;
    for (int i = 0; i < 56; i++) begin
      if (i < 16) begin
        we = 1'b1; f3 = 3'b010; addr = 32'h400 + 32'(4*i); wd = $urandom;
      end else begin
        we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
        addr = 32'h400 + 32'($urandom_range(0, 32'h3B)); wd = $urandom;
      end
      model_access(we, f3, addr, wd, m);
      sb.push_back(m);
      xfer(we, f3, addr, wd, rd, er, lat);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rand[%0d] we=%b f3=%b addr=%h rdata got=%h want=%h", i, we, f3, addr, rd, e.rdata); end
      checks++; if (er !== e.err)   begin failures++; $display("FAIL rand[%0d] err got=%b want=%b", i, er, e.err); end
      checks++; if (lat !== e.lat)  begin failures++; $display("FAIL rand[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misalign();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
